bot_motion_ctrl: RTL and testbench

- Producer side of the bot icon display interface: generates bot_LocX / bot_LocY / bot_Orie for the icon drawing block.
- Accepts target coordinates from the CPU through a valid/ready handshake.
- Steps the displayed position toward the target by one location unit per step interval, changing only at frame boundaries (no tearing).
- Derives the 8-way orientation code from the step direction.

---
 rtl/bot_motion_ctrl_pkg.sv | 49 ++++
 rtl/bot_orient_enc.sv | 27 ++
 rtl/bot_motion_ctrl.sv | 119 +++++++++++
 tb/tb_bot_motion_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/bot_motion_ctrl_pkg.sv
// rtl/bot_motion_ctrl_pkg.sv - shared types and screen constants for the bot icon motion controller
package bot_motion_ctrl_pkg;

    typedef enum logic [2:0] {
        ORIE_N  = 3'd0,
        ORIE_NE = 3'd1,
        ORIE_E  = 3'd2,
        ORIE_SE = 3'd3,
        ORIE_S  = 3'd4,
        ORIE_SW = 3'd5,
        ORIE_W  = 3'd6,
        ORIE_NW = 3'd7
    } orient_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MOVE = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        DIR_ZERO = 2'd0,
        DIR_POS  = 2'd1,
        DIR_NEG  = 2'd2
    } dir_t;

    localparam logic [7:0] SCR_LOC_MIN = 8'd2;
    localparam logic [7:0] SCR_X_MAX   = 8'd158;
    localparam logic [7:0] SCR_Y_MAX   = 8'd118;

    function automatic logic [7:0] clamp_loc(input logic [7:0] v, input logic [7:0] lo,
                                             input logic [7:0] hi);
        if (v < lo) return lo;
        else if (v > hi) return hi;
        else return v;
    endfunction

    function automatic dir_t step_dir(input logic [7:0] cur, input logic [7:0] tgt);
        if (tgt > cur) return DIR_POS;
        else if (tgt < cur) return DIR_NEG;
        else return DIR_ZERO;
    endfunction

    function automatic logic [7:0] apply_dir(input logic [7:0] cur, input dir_t dir);
        if (dir == DIR_POS) return cur + 8'd1;
        else if (dir == DIR_NEG) return cur - 8'd1;
        else return cur;
    endfunction

endpackage

// File: rtl/bot_orient_enc.sv
// rtl/bot_orient_enc.sv - maps per-axis step direction to the 8-way icon orientation
module bot_orient_enc
    import bot_motion_ctrl_pkg::*;
(
    input  dir_t    x_dir,
    input  dir_t    y_dir,
    input  orient_t held,
    output orient_t orie
);

    // Screen Y grows downward, so a negative Y step points north.
    always_comb begin
        orie = held;
        case ({x_dir, y_dir})
            {DIR_ZERO, DIR_NEG}:  orie = ORIE_N;
            {DIR_POS,  DIR_NEG}:  orie = ORIE_NE;
            {DIR_POS,  DIR_ZERO}: orie = ORIE_E;
            {DIR_POS,  DIR_POS}:  orie = ORIE_SE;
            {DIR_ZERO, DIR_POS}:  orie = ORIE_S;
            {DIR_NEG,  DIR_POS}:  orie = ORIE_SW;
            {DIR_NEG,  DIR_ZERO}: orie = ORIE_W;
            {DIR_NEG,  DIR_NEG}:  orie = ORIE_NW;
            default:              orie = held;
        endcase
    end

endmodule

// File: rtl/bot_motion_ctrl.sv
// rtl/bot_motion_ctrl.sv - steps the bot icon toward a CPU-supplied target at frame boundaries
module bot_motion_ctrl
    import bot_motion_ctrl_pkg::*;
#(
    parameter logic [7:0] INIT_X      = 8'd80,
    parameter logic [7:0] INIT_Y      = 8'd60,
    parameter logic [7:0] LOC_MIN     = SCR_LOC_MIN,
    parameter logic [7:0] X_MAX       = SCR_X_MAX,
    parameter logic [7:0] Y_MAX       = SCR_Y_MAX,
    parameter logic [3:0] STEP_FRAMES = 4'd1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic       tgt_valid,
    output logic       tgt_ready,
    input  logic [7:0] tgt_x,
    input  logic [7:0] tgt_y,
    output logic [7:0] bot_LocX,
    output logic [7:0] bot_LocY,
    output logic [2:0] bot_Orie,
    output logic       moving,
    output logic       arrived
);

    localparam logic [3:0] STEP_LAST = STEP_FRAMES - 4'd1;

    state_t     state;
    logic [7:0] tgt_x_q;
    logic [7:0] tgt_y_q;
    logic [3:0] step_cnt;
    orient_t    orie_q;

    logic [7:0] clamp_x;
    logic [7:0] clamp_y;
    dir_t       x_dir;
    dir_t       y_dir;
    logic [7:0] next_x;
    logic [7:0] next_y;
    orient_t    next_orie;
    logic       transfer;
    logic       step_fire;

    always_comb begin
        clamp_x   = clamp_loc(tgt_x, LOC_MIN, X_MAX);
        clamp_y   = clamp_loc(tgt_y, LOC_MIN, Y_MAX);
        x_dir     = step_dir(bot_LocX, tgt_x_q);
        y_dir     = step_dir(bot_LocY, tgt_y_q);
        next_x    = apply_dir(bot_LocX, x_dir);
        next_y    = apply_dir(bot_LocY, y_dir);
        transfer  = tgt_valid && tgt_ready;
        step_fire = (state == ST_MOVE) && frame_tick && (step_cnt == STEP_LAST);
    end

    bot_orient_enc u_orient_enc (
        .x_dir (x_dir),
        .y_dir (y_dir),
        .held  (orie_q),
        .orie  (next_orie)
    );

    assign bot_Orie = orie_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            tgt_x_q   <= INIT_X;
            tgt_y_q   <= INIT_Y;
            step_cnt  <= 4'd0;
            bot_LocX  <= INIT_X;
            bot_LocY  <= INIT_Y;
            orie_q    <= ORIE_N;
            tgt_ready <= 1'b1;
            moving    <= 1'b0;
            arrived   <= 1'b0;
        end else begin
            arrived <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A tick arriving with a transfer is ignored: IDLE never steps.
                    if (transfer) begin
                        if (clamp_x == bot_LocX && clamp_y == bot_LocY) begin
                            arrived <= 1'b1;
                        end else begin
                            tgt_x_q   <= clamp_x;
                            tgt_y_q   <= clamp_y;
                            step_cnt  <= 4'd0;
                            state     <= ST_MOVE;
                            tgt_ready <= 1'b0;
                            moving    <= 1'b1;
                        end
                    end
                end
                ST_MOVE: begin
                    if (step_fire) begin
                        step_cnt <= 4'd0;
                        bot_LocX <= next_x;
                        bot_LocY <= next_y;
                        orie_q   <= next_orie;
                        if (next_x == tgt_x_q && next_y == tgt_y_q) begin
                            state     <= ST_IDLE;
                            tgt_ready <= 1'b1;
                            moving    <= 1'b0;
                            arrived   <= 1'b1;
                        end
                    end else if (frame_tick) begin
                        step_cnt <= step_cnt + 4'd1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    tgt_ready <= 1'b1;
                    moving    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bot_motion_ctrl.sv
// tb/tb_bot_motion_ctrl.sv - scoreboard bench for bot_motion_ctrl at divider 1 and divider 3
module tb_bot_motion_ctrl;

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic [2:0] o;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       tgt_valid = 1'b0;
    logic [7:0] tgt_x = 8'd0;
    logic [7:0] tgt_y = 8'd0;

    logic       rdy1, mov1, arr1, rdy3, mov3, arr3;
    logic [7:0] x1, y1, x3, y3;
    logic [2:0] o1, o3;

    logic       sel = 1'b0;
    logic [7:0] ox, oy;
    logic [2:0] oo;
    logic       ordy, omov, oarr;

    int   vectors = 0;
    int   fails = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    bot_motion_ctrl #(.STEP_FRAMES(4'd1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .tgt_valid(tgt_valid),
        .tgt_ready(rdy1), .tgt_x(tgt_x), .tgt_y(tgt_y), .bot_LocX(x1), .bot_LocY(y1),
        .bot_Orie(o1), .moving(mov1), .arrived(arr1)
    );

    bot_motion_ctrl #(.STEP_FRAMES(4'd3)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .tgt_valid(tgt_valid),
        .tgt_ready(rdy3), .tgt_x(tgt_x), .tgt_y(tgt_y), .bot_LocX(x3), .bot_LocY(y3),
        .bot_Orie(o3), .moving(mov3), .arrived(arr3)
    );

    always_comb begin
        ox   = sel ? x3 : x1;
        oy   = sel ? y3 : y1;
        oo   = sel ? o3 : o1;
        ordy = sel ? rdy3 : rdy1;
        omov = sel ? mov3 : mov1;
        oarr = sel ? arr3 : arr1;
    end

    task automatic chk(input string tag, input int obs, input int expv);
        vectors++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic cycle(input logic ft, input logic v, input logic [7:0] x, input logic [7:0] y);
        frame_tick = ft;
        tgt_valid  = v;
        tgt_x      = x;
        tgt_y      = y;
        @(negedge clk);
    endtask

    task automatic push(input int x, input int y, input int o);
        exp_t e;
        e.x = 8'(x);
        e.y = 8'(y);
        e.o = 3'(o);
        sb.push_back(e);
    endtask

    task automatic pop_chk(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_x"}, int'(ox), int'(e.x));
            chk({tag, "_y"}, int'(oy), int'(e.y));
            chk({tag, "_o"}, int'(oo), int'(e.o));
        end
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 8'd0, 8'd0);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        sb.delete();
    endtask

    initial begin
        int ex, ey, eo, k, steps;
        logic dxm, dym;

        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Reset state of both instances
        sel = 1'b0;
        push(80, 60, 0);
        pop_chk("rst1");
        chk("rst1_ready", ordy, 1);
        chk("rst1_moving", omov, 0);
        chk("rst1_arrived", oarr, 0);
        sel = 1'b1;
        push(80, 60, 0);
        pop_chk("rst3");
        chk("rst3_ready", ordy, 1);
        chk("rst3_moving", omov, 0);

        // Diagonal NE move, one step per tick
        sel = 1'b0;
        cycle(1'b0, 1'b1, 8'd83, 8'd57);
        chk("diag_accept_moving", omov, 1);
        chk("diag_accept_ready", ordy, 0);
        for (int i = 0; i < 3; i++) begin
            push(81 + i, 59 - i, 1);
            cycle(1'b1, 1'b0, 8'd0, 8'd0);
            pop_chk("diag_step");
            chk("diag_arrived", oarr, (i == 2) ? 1 : 0);
        end
        cycle(1'b0, 1'b0, 8'd0, 8'd0);
        chk("diag_after_arrived", oarr, 0);
        chk("diag_after_ready", ordy, 1);
        chk("diag_after_moving", omov, 0);

        // Westward move with a 3-tick divider, idle cycles between ticks
        do_reset();
        sel = 1'b1;
        cycle(1'b0, 1'b1, 8'd78, 8'd60);
        chk("div_accept_moving", omov, 1);
        for (k = 0; k < 6; k++) begin
            steps = (k + 1) / 3;
            push(80 - steps, 60, (steps > 0) ? 6 : 0);
            cycle(1'b1, 1'b0, 8'd0, 8'd0);
            pop_chk("div_tick");
            chk("div_arrived", oarr, (k == 5) ? 1 : 0);
            if (k < 5) begin
                push(80 - steps, 60, (steps > 0) ? 6 : 0);
                cycle(1'b0, 1'b0, 8'd0, 8'd0);
                pop_chk("div_hold");
            end
        end
        cycle(1'b0, 1'b0, 8'd0, 8'd0);
        chk("div_end_ready", ordy, 1);

        // Out-of-range target clamps to (158,2)
        do_reset();
        sel = 1'b0;
        cycle(1'b0, 1'b1, 8'd255, 8'd0);
        ex = 80;
        ey = 60;
        eo = 0;
        while (ex != 158 || ey != 2) begin
            dxm = (ex < 158);
            dym = (ey > 2);
            if (dxm) ex++;
            if (dym) ey--;
            eo = (dxm && dym) ? 1 : 2;
            push(ex, ey, eo);
            cycle(1'b1, 1'b0, 8'd0, 8'd0);
            pop_chk("clamp_step");
            chk("clamp_arrived", oarr, (ex == 158 && ey == 2) ? 1 : 0);
        end
        cycle(1'b0, 1'b0, 8'd0, 8'd0);
        chk("clamp_end_moving", omov, 0);

        // Equal target, backpressure, and transfer+tick collision in IDLE
        do_reset();
        cycle(1'b0, 1'b1, 8'd80, 8'd60);
        chk("eq_arrived", oarr, 1);
        chk("eq_moving", omov, 0);
        chk("eq_ready", ordy, 1);
        push(80, 60, 0);
        pop_chk("eq_pos");
        cycle(1'b0, 1'b0, 8'd0, 8'd0);
        chk("eq_arrived_clear", oarr, 0);
        cycle(1'b0, 1'b1, 8'd82, 8'd60);
        push(81, 60, 2);
        cycle(1'b1, 1'b1, 8'd10, 8'd10);
        pop_chk("bp_step1");
        chk("bp_ready_low", ordy, 0);
        push(82, 60, 2);
        cycle(1'b1, 1'b1, 8'd10, 8'd10);
        pop_chk("bp_step2");
        chk("bp_arrived", oarr, 1);
        chk("bp_ready_back", ordy, 1);
        push(82, 60, 2);
        cycle(1'b1, 1'b1, 8'd10, 8'd10);
        pop_chk("coll_no_step");
        chk("coll_moving", omov, 1);
        push(81, 59, 7);
        cycle(1'b1, 1'b0, 8'd0, 8'd0);
        pop_chk("coll_nw_step");

        // Asynchronous reset in the middle of a move
        do_reset();
        cycle(1'b0, 1'b1, 8'd83, 8'd57);
        cycle(1'b1, 1'b0, 8'd0, 8'd0);
        push(82, 58, 1);
        cycle(1'b1, 1'b0, 8'd0, 8'd0);
        pop_chk("mid_pos");
        reset_n = 1'b0;
        #1;
        push(80, 60, 0);
        pop_chk("async_rst");
        chk("async_rst_moving", omov, 0);
        chk("async_rst_ready", ordy, 1);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
